// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush-to-bubble,
// halt latching and a sticky error flag. Sized per stage through parameters.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int unsigned       HALT_BIT    = 0,
    parameter bit                HALT_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_inst_misalign,
    input  logic              in_mem_misalign,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_err,
    output logic              err_sticky,
    output logic              halted,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              push, pop, in_err;
    logic              load_head_in, load_head_skid, load_skid;
    logic [DATA_W-1:0] head_data, skid_data;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    logic              head_err, skid_err;
    logic              halted_q;

    assign in_err    = in_inst_misalign | in_mem_misalign;
    assign in_ready  = (state != FULL) && !halted_q;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Flush overrides any same-cycle push or pop; nothing is loaded.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt    = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_head_in = 1'b1;
                    end else if (push) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data <= '0;
            head_ctrl <= '0;
            head_err  <= 1'b0;
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_head_in) begin
                head_data <= in_data;
                head_ctrl <= in_ctrl;
                head_err  <= in_err;
            end else if (load_head_skid) begin
                head_data <= skid_data;
                head_ctrl <= skid_ctrl;
                head_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
                skid_err  <= in_err;
            end
        end
    end

    // err_sticky records every accepted error entry, even one flushed later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            if (push && in_err) err_sticky <= 1'b1;
            if (flush)
                halted_q <= 1'b0;
            else if (HALT_EN && push && in_ctrl[HALT_BIT])
                halted_q <= 1'b1;
        end
    end

    assign halted    = halted_q;
    assign out_data  = head_data;
    assign out_ctrl  = out_valid ? head_ctrl : CTRL_BUBBLE;
    assign out_err   = out_valid & head_err;
    assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: stimulus queues expected entries,
// a negedge monitor pops and compares each entry the DUT hands downstream.
module tb_pipe_stage_skid;

    localparam logic [15:0] BUBBLE = 16'h0013;
    localparam logic [15:0] HALT   = 16'h8000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] in_data = '0;
    logic [15:0] in_ctrl = '0;
    logic        in_inst_misalign = 1'b0, in_mem_misalign = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] out_data;
    logic [15:0] out_ctrl;
    logic        out_err, err_sticky, halted;
    logic [1:0]  occupancy;

    typedef struct {
        logic [63:0] d;
        logic [15:0] c;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pipe_stage_skid #(
        .DATA_W(64),
        .CTRL_W(16),
        .CTRL_BUBBLE(BUBBLE),
        .HALT_BIT(15),
        .HALT_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_ctrl(in_ctrl),
        .in_inst_misalign(in_inst_misalign),
        .in_mem_misalign(in_mem_misalign),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ctrl(out_ctrl),
        .out_err(out_err),
        .err_sticky(err_sticky),
        .halted(halted),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic [15:0] c,
                         input logic im, input logic mm, input bit expect_accept);
        exp_t e;
        in_valid         = 1'b1;
        in_data          = d;
        in_ctrl          = c;
        in_inst_misalign = im;
        in_mem_misalign  = mm;
        if (expect_accept) begin
            e.d = d;
            e.c = c;
            e.e = im | mm;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid         = 1'b0;
        in_inst_misalign = 1'b0;
        in_mem_misalign  = 1'b0;
    endtask

    // Monitor: every handshake on the output side must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got data=%h ctrl=%h expected no entry", out_data, out_ctrl);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
                chk("out_err", 64'(out_err), 64'(e.e));
            end
        end
    end

    initial begin
        // Reset asserted mid-cycle: outputs must settle without a clock edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(BUBBLE));
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_err_sticky", 64'(err_sticky), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single entry, 1-cycle latency
        step();
        out_ready = 1'b1;
        drive(64'h0123_4567_89AB_CDEF, 16'h00A5, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        @(negedge clk);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_occ", 64'(occupancy), 64'd1);
        step();
        @(negedge clk);
        chk("single_drained", 64'(out_valid), 64'd0);
        chk("single_bubble", 64'(out_ctrl), 64'(BUBBLE));

        // Skid fill then drain in order
        step();
        out_ready = 1'b0;
        drive(64'd1, 16'h0010, 1'b0, 1'b0, 1'b1);
        step();
        drive(64'd2, 16'h0020, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("skid_occ1", 64'(occupancy), 64'd1);
        step();
        idle();
        @(negedge clk);
        chk("skid_occ2", 64'(occupancy), 64'd2);
        chk("skid_full_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("skid_drain_occ1", 64'(occupancy), 64'd1);
        step();
        @(negedge clk);
        chk("skid_drain_occ0", 64'(occupancy), 64'd0);

        // Streaming 0..9 with occupancy pinned at 1
        for (int i = 0; i < 10; i++) begin
            step();
            drive(64'(i), 16'(i << 4), 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            if (i > 0) chk("stream_occ", 64'(occupancy), 64'd1);
        end
        step();
        idle();
        @(negedge clk);
        chk("stream_tail_occ", 64'(occupancy), 64'd1);
        step();
        @(negedge clk);
        chk("stream_empty", 64'(occupancy), 64'd0);

        // Flush from FULL with a simultaneous push of C
        step();
        out_ready = 1'b0;
        drive(64'hA, 16'h0030, 1'b0, 1'b0, 1'b0);
        step();
        drive(64'hB, 16'h0040, 1'b0, 1'b0, 1'b0);
        step();
        drive(64'hC, 16'h0050, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_pre_occ", 64'(occupancy), 64'd2);
        step();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_bubble", 64'(out_ctrl), 64'(BUBBLE));
        chk("flush_err", 64'(out_err), 64'd0);
        step();
        out_ready = 1'b1;
        step();
        step();

        // Halt: entry drains, further input is refused until flush
        drive(64'h4A17, HALT | 16'h0060, 1'b0, 1'b0, 1'b1);
        step();
        drive(64'hDEAD, 16'h0070, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("halt_set", 64'(halted), 64'd1);
        chk("halt_ready", 64'(in_ready), 64'd0);
        chk("halt_valid", 64'(out_valid), 64'd1);
        step();
        @(negedge clk);
        chk("halt_hold", 64'(halted), 64'd1);
        chk("halt_refuse_occ", 64'(occupancy), 64'd0);
        step();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("halt_clear", 64'(halted), 64'd0);
        chk("halt_ready_back", 64'(in_ready), 64'd1);

        // Errors: only flagged entries carry out_err, sticky persists
        chk("err_sticky_pre", 64'(err_sticky), 64'd0);
        step();
        drive(64'h111, 16'h0080, 1'b0, 1'b1, 1'b1);
        step();
        drive(64'h222, 16'h0090, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("err_sticky_set", 64'(err_sticky), 64'd1);
        step();
        drive(64'h333, 16'h00A0, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("err_sticky_hold", 64'(err_sticky), 64'd1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        #2 rst = 1'b1;
        #1;
        chk("err_sticky_rst", 64'(err_sticky), 64'd0);
        chk("rst2_occ", 64'(occupancy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
